// File: rtl/temp_cmd_pkg.sv
// Shared definitions for the temperature-sensor command frame path.
// TEMP_CMD_CHK_EN adds the checksum state and helper.
package temp_cmd_pkg;

    localparam logic [7:0] FRAME_HDR    = 8'hA5;

    localparam logic [7:0] CMD_SET_HIGH = 8'h01;
    localparam logic [7:0] CMD_SET_LOW  = 8'h02;
    localparam logic [7:0] CMD_SEND     = 8'h03;

    // Bit slots within one UART character: start, 8 data bits, stop.
    localparam logic [3:0] UART_STOP_IDX = 4'd9;
    localparam logic [3:0] UART_LAST_DATA_IDX = 4'd8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        CMD  = 3'd2,
        DATA = 3'd3
`ifdef TEMP_CMD_CHK_EN
        ,
        CHK  = 3'd4
`endif
    } frame_state_e;

`ifdef TEMP_CMD_CHK_EN
    function automatic logic [7:0] frame_chk(input logic [7:0] cmd_b, input logic [7:0] data_b);
        return FRAME_HDR ^ cmd_b ^ data_b;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with its own baud counter; a load on the final cycle
// of a stop bit chains the next character with no idle gap.
module uart_tx_byte
    import temp_cmd_pkg::*;
#(
    parameter int BIT_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       ready,
    output logic       tx
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    byte_q, byte_d;
    logic          active_q, active_d;
    logic          tx_q, tx_d;

    logic          stop_end;

    assign stop_end = active_q && (bit_q == UART_STOP_IDX) && (cyc_q == CYC_LAST);
    assign ready    = !active_q || stop_end;
    assign tx       = tx_q;

    always_comb begin
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        active_d = active_q;
        tx_d     = tx_q;
        if (load) begin
            byte_d   = byte_in;
            bit_d    = 4'd0;
            cyc_d    = '0;
            active_d = 1'b1;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (cyc_q == CYC_LAST) begin
                cyc_d = '0;
                if (bit_q == UART_STOP_IDX) begin
                    active_d = 1'b0;
                    bit_d    = 4'd0;
                    tx_d     = 1'b1;
                end else begin
                    // Slot k+1 carries data bit k; slot 9 is the stop bit.
                    bit_d = bit_q + 4'd1;
                    tx_d  = (bit_q == UART_LAST_DATA_IDX) ? 1'b1 : byte_q[bit_q[2:0]];
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q    <= '0;
            bit_q    <= 4'd0;
            byte_q   <= 8'd0;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/temp_cmd_frame_tx.sv
// UART command-frame transmitter: A5, cmd, data and, with TEMP_CMD_CHK_EN
// defined, an XOR checksum byte, sent back to back as 8N1 characters.
//
// state | meaning
// IDLE  | line idle, busy low, waiting for start
// HDR   | serializing the 0xA5 header
// CMD   | serializing the captured command byte
// DATA  | serializing the captured data byte
// CHK   | serializing the checksum (TEMP_CMD_CHK_EN only)
module temp_cmd_frame_tx
    import temp_cmd_pkg::*;
#(
    parameter int CLK_FREQ = 10000,
    parameter int BAUD     = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;

    frame_state_e state_q, state_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [7:0]   data_q, data_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         ser_load;
    logic [7:0]   ser_byte;
    logic         ser_ready;
    logic         ser_tx;

    uart_tx_byte #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_ser (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ser_load),
        .byte_in(ser_byte),
        .ready  (ser_ready),
        .tx     (ser_tx)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign tx   = ser_tx;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ser_load = 1'b0;
        ser_byte = FRAME_HDR;
        case (state_q)
            IDLE: begin
                // Header load coincides with acceptance so the start bit
                // appears in the very next cycle.
                if (start) begin
                    cmd_d    = cmd;
                    data_d   = data;
                    busy_d   = 1'b1;
                    ser_load = 1'b1;
                    ser_byte = FRAME_HDR;
                    state_d  = HDR;
                end
            end
            HDR: begin
                if (ser_ready) begin
                    ser_load = 1'b1;
                    ser_byte = cmd_q;
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (ser_ready) begin
                    ser_load = 1'b1;
                    ser_byte = data_q;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (ser_ready) begin
`ifdef TEMP_CMD_CHK_EN
                    ser_load = 1'b1;
                    ser_byte = frame_chk(cmd_q, data_q);
                    state_d  = CHK;
`else
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
`endif
                end
            end
`ifdef TEMP_CMD_CHK_EN
            CHK: begin
                if (ser_ready) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= 8'd0;
            data_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_temp_cmd_frame_tx.sv
// Scoreboard bench for temp_cmd_frame_tx: a frame-level model queues expected
// bytes and start-bit cycles; a line decoder pops and compares them.
module tb_temp_cmd_frame_tx;

    localparam int CLK_FREQ = 10000;
    localparam int BAUD     = 1000;
    localparam int BITC     = CLK_FREQ / BAUD;
`ifdef TEMP_CMD_CHK_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int FRAME_CYC = 10 * BITC * NB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cmd   = 8'd0;
    logic [7:0] data  = 8'd0;
    logic       busy;
    logic       done;
    logic       tx;

    temp_cmd_frame_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .cmd  (cmd),
        .data (data),
        .busy (busy),
        .done (done),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_bytes[$];
    int         exp_starts[$];

    bit         m_active = 1'b0;
    int         m_acc    = 0;

    bit         dec_on   = 1'b0;
    int         dec_s    = 0;
    logic [7:0] dec_byte = 8'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    // Model and monitor: everything evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        bit exp_busy;
        bit exp_done;
        int off;
        int k;
        if (!rst_n) begin
            check("rst_tx",   32'(tx),   32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            m_active = 1'b0;
            dec_on   = 1'b0;
            exp_bytes.delete();
            exp_starts.delete();
        end else begin
            exp_busy = m_active && (cyc >= m_acc + 1) && (cyc <= m_acc + FRAME_CYC);
            exp_done = m_active && (cyc == m_acc + 1 + FRAME_CYC);
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                check("tx_at_done", 32'(tx), 32'd1);
                m_active = 1'b0;
            end

            if (!dec_on) begin
                if (tx == 1'b0) begin
                    dec_on = 1'b1;
                    dec_s  = cyc;
                    if (exp_starts.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_start actual=start_bit required=idle cycle=%0d", cyc);
                    end else begin
                        check("start_cycle", 32'(cyc), 32'(exp_starts.pop_front()));
                    end
                end
            end else begin
                off = cyc - dec_s;
                if (off % BITC == BITC / 2) begin
                    k = off / BITC;
                    if (k == 0) begin
                        check("start_bit_mid", 32'(tx), 32'd0);
                    end else if (k <= 8) begin
                        dec_byte[k-1] = tx;
                    end else begin
                        check("stop_bit", 32'(tx), 32'd1);
                        if (exp_bytes.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_byte actual=0x%0h required=none cycle=%0d", dec_byte, cyc);
                        end else begin
                            check("byte", 32'(dec_byte), 32'(exp_bytes.pop_front()));
                        end
                        dec_on = 1'b0;
                    end
                end
            end

            if (start && !m_active) begin
                m_active = 1'b1;
                m_acc    = cyc;
                exp_bytes.push_back(8'hA5);
                exp_bytes.push_back(cmd);
                exp_bytes.push_back(data);
`ifdef TEMP_CMD_CHK_EN
                exp_bytes.push_back(8'hA5 ^ cmd ^ data);
`endif
                for (int b = 0; b < NB; b++)
                    exp_starts.push_back(cyc + 1 + 10 * BITC * b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] c, input logic [7:0] d);
        cmd   = c;
        data  = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 5000) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(m_active), 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic frame
        pulse(8'h01, 8'h3C);
        wait_idle();
        repeat (5) tick();

        // Re-pulse 150 cycles in with different command: must be ignored
        pulse(8'h01, 8'h3C);
        repeat (149) tick();
        cmd   = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        cmd   = 8'h55;
        data  = 8'hAA;
        wait_idle();
        repeat (5) tick();

        // Start held high: back-to-back frames, one idle (done) cycle between
        cmd   = 8'h01;
        data  = 8'h3C;
        start = 1'b1;
        repeat (900) tick();
        start = 1'b0;
        wait_idle();
        repeat (5) tick();

        // Reset 200 cycles into a frame, then a clean frame
        pulse(8'h01, 8'h3C);
        repeat (199) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        pulse(8'h01, 8'h3C);
        wait_idle();
        repeat (5) tick();

        // Zero checksum
        pulse(8'h02, 8'hA7);
        wait_idle();
        repeat (3) tick();

        // Randomized: input churn and stray starts, model decides acceptance
        for (int i = 0; i < 6; i++) begin
            pulse(8'($urandom), 8'($urandom));
            n = $urandom_range(50, 700);
            repeat (n) begin
                cmd   = 8'($urandom);
                data  = 8'($urandom);
                start = ($urandom_range(0, 39) == 0);
                tick();
            end
            start = 1'b0;
            wait_idle();
            repeat ($urandom_range(1, 5)) tick();
        end

        repeat (20) tick();
        check("leftover_bytes",  32'(exp_bytes.size()),  32'd0);
        check("leftover_starts", 32'(exp_starts.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
